// File: rtl/vigna_bus_pkg.sv
// vigna_bus_pkg: shared state encoding, bus widths and
// default error data for the vigna bus arbiter.
package vigna_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/vigna_bus_arbiter_if.sv
// vigna_bus_arbiter_if: packed per-master request bus plus
// the single shared slave port seen by the arbiter.
interface vigna_bus_arbiter_if
  import vigna_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4
);

  logic [NUM_MASTERS-1:0]        m_valid;
  logic [NUM_MASTERS-1:0]        m_ready;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS*STRB_W-1:0] m_wstrb;
  logic [DATA_W-1:0]             m_rdata;

  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic [DATA_W-1:0] s_rdata;

  logic [NUM_MASTERS-1:0] grant;
  logic                   timeout_err;

  modport arb (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    input  s_ready, s_rdata,
    output m_ready, m_rdata,
    output s_valid, s_addr, s_wdata, s_wstrb,
    output grant, timeout_err
  );

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata, grant
  );

  modport slave (
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );

endinterface

// File: rtl/vigna_rr_pick.sv
// vigna_rr_pick: combinational round-robin picker, first set
// request scanning upward from last+1, wrapping modulo N.
module vigna_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    jj     = '0;
    for (int k = 1; k <= N; k++) begin
      j  = (int'(last) + k) % N;
      jj = IDX_W'(j);
      if (!any && req[jj]) begin
        any        = 1'b1;
        onehot[jj] = 1'b1;
        idx        = jj;
      end
    end
  end

endmodule

// File: rtl/vigna_bus_arbiter.sv
// vigna_bus_arbiter: N-master round-robin valid/ready arbiter.
// Define VIGNA_ARB_TIMEOUT_EN to enable the BUSY watchdog.
module vigna_bus_arbiter
  import vigna_bus_pkg::*;
#(
  parameter int                NUM_MASTERS    = 4,
  parameter int                IDX_W          = 2,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA      = DEF_ERR_RDATA
) (
  input logic          clk,
  input logic          reset,
  vigna_bus_arbiter_if.arb bus
);

  arb_state_e             state;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       last_idx;
  logic [NUM_MASTERS-1:0] grant_q;

  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  logic busy;
  logic tmo;
  logic done;

  logic [ADDR_W-1:0] addr_a  [NUM_MASTERS];
  logic [DATA_W-1:0] wdata_a [NUM_MASTERS];
  logic [STRB_W-1:0] wstrb_a [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_a[i]  = bus.m_addr[ADDR_W*i +: ADDR_W];
    assign wdata_a[i] = bus.m_wdata[DATA_W*i +: DATA_W];
    assign wstrb_a[i] = bus.m_wstrb[STRB_W*i +: STRB_W];
  end

  vigna_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (bus.m_valid),
    .last   (last_idx),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign busy = (state == BUSY);
  assign done = busy && (bus.s_ready || tmo);

`ifdef VIGNA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             err_q;

  // s_ready in the expiry cycle wins over the watchdog
  assign tmo = busy && !bus.s_ready &&
               (cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (!busy)
        cnt <= '0;
      else if (!bus.s_ready && !tmo)
        cnt <= cnt + CNT_W'(1);
      if (tmo)
        err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = err_q;
`else
  wire unused_cfg = |TIMEOUT_CYCLES;

  assign tmo             = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_q  <= '0;
      idx      <= '0;
      last_idx <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            state   <= BUSY;
            grant_q <= pick_oh;
            idx     <= pick_idx;
          end
        end
        BUSY: begin
          if (done) begin
            state    <= IDLE;
            grant_q  <= '0;
            last_idx <= idx;
          end
        end
      endcase
    end
  end

  assign bus.grant = grant_q;

  always_comb begin
    bus.m_ready = '0;
    if (done)
      bus.m_ready[idx] = 1'b1;
    bus.s_valid = busy && bus.m_valid[idx] && !tmo;
    bus.s_addr  = busy ? addr_a[idx]  : '0;
    bus.s_wdata = busy ? wdata_a[idx] : '0;
    bus.s_wstrb = busy ? wstrb_a[idx] : '0;
    if (tmo)
      bus.m_rdata = ERR_RDATA;
    else
      bus.m_rdata = busy ? bus.s_rdata : '0;
  end

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// tb_vigna_bus_arbiter: directed + random stimulus against a
// rotation-order reference model of the arbiter.
module tb_vigna_bus_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;
`ifdef VIGNA_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  vigna_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  vigna_bus_arbiter #(
    .NUM_MASTERS    (N),
    .IDX_W          (2),
    .TIMEOUT_CYCLES (TMO),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner / last-served / wait count in plain ints
  bit md_busy;
  int md_own, md_last, md_cnt, md_c;
  bit md_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      md_busy = 1'b0;
      md_own  = 0;
      md_last = N - 1;
      md_cnt  = 0;
      md_err  = 1'b0;
    end else if (!md_busy) begin
      for (int k = 1; k <= N; k++) begin
        md_c = (md_last + k) % N;
        if (!md_busy && bus.m_valid[md_c]) begin
          md_busy = 1'b1;
          md_own  = md_c;
          md_cnt  = 0;
        end
      end
    end else if (bus.s_ready) begin
      md_busy = 1'b0;
      md_last = md_own;
    end else if (TMO_EN && md_cnt == TMO) begin
      md_busy = 1'b0;
      md_last = md_own;
      md_err  = 1'b1;
    end else begin
      md_cnt++;
    end
  end

  logic [N-1:0] eg, er;
  bit tm, esv;

  always @(negedge clk) begin
    if (chk_en) begin
      tm  = TMO_EN && md_busy && md_cnt == TMO && !bus.s_ready;
      eg  = md_busy ? N'(1 << md_own) : '0;
      er  = (md_busy && (bus.s_ready || tm)) ? eg : '0;
      esv = md_busy && bus.m_valid[md_own] && !tm;
      chk("cmp_grant", 32'(bus.grant), 32'(eg));
      chk("cmp_m_ready", 32'(bus.m_ready), 32'(er));
      chk("cmp_s_valid", 32'(bus.s_valid), 32'(esv));
      chk("cmp_timeout_err", 32'(bus.timeout_err), 32'(md_err));
      if (md_busy) begin
        chk("cmp_s_addr", bus.s_addr, bus.m_addr[32*md_own +: 32]);
        chk("cmp_s_wdata", bus.s_wdata, bus.m_wdata[32*md_own +: 32]);
        chk("cmp_s_wstrb", 32'(bus.s_wstrb),
            32'(bus.m_wstrb[4*md_own +: 4]));
      end
      if (er != '0)
        chk("cmp_m_rdata", bus.m_rdata,
            tm ? 32'hDEAD_BEEF : bus.s_rdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input bit v, input logic [31:0] a,
                       input logic [31:0] w, input logic [3:0] s);
    bus.m_valid[i]        = v;
    bus.m_addr[32*i +: 32] = a;
    bus.m_wdata[32*i +: 32] = w;
    bus.m_wstrb[4*i +: 4]  = s;
  endtask

  logic [N-1:0] exp_g [10];
  int  mrc [N];
  int  sv_at, rd_at;
  logic [31:0] rdat;
  logic svl;
  bit  pend [N];
  bit  fin [N];
  int  waits [N];
  logic [N-1:0] mr;

  initial begin
    bus.m_valid = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    bus.s_ready = 1'b0;
    bus.s_rdata = '0;
    #1 reset = 1'b1;

    // reset state
    smp();
    chk_en = 1'b1;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_s_valid", 32'(bus.s_valid), 32'h0);
    chk("rst_m_ready", 32'(bus.m_ready), 32'h0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'h0);
    chk("rst_s_addr", bus.s_addr, 32'h0);

    // single master 0 read, slave ready on second BUSY cycle
    cyc();
    reset = 1'b0;
    cyc();
    set_m(0, 1'b1, 32'h1000_0040, 32'h0, 4'h0);
    smp();
    chk("t1_idle_s_valid", 32'(bus.s_valid), 32'h0);
    cyc();
    smp();
    chk("t1_s_valid", 32'(bus.s_valid), 32'h1);
    chk("t1_s_addr", bus.s_addr, 32'h1000_0040);
    chk("t1_grant", 32'(bus.grant), 32'h1);
    chk("t1_wait_m_ready", 32'(bus.m_ready), 32'h0);
    cyc();
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'hCAFE_0001;
    smp();
    chk("t1_m_ready", 32'(bus.m_ready), 32'h1);
    chk("t1_m_rdata", bus.m_rdata, 32'hCAFE_0001);
    cyc();
    bus.s_ready = 1'b0;
    bus.m_valid[0] = 1'b0;
    smp();
    chk("t1_grant_back", 32'(bus.grant), 32'h0);
    chk("t1_m_ready_once", 32'(bus.m_ready), 32'h0);

    // master 1 write while master 0 waits
    cyc();
    set_m(1, 1'b1, 32'h2000_0004, 32'h1234_5678, 4'b0110);
    set_m(0, 1'b1, 32'h1000_0080, 32'h0, 4'h0);
    smp();
    cyc();
    smp();
    chk("t4_grant", 32'(bus.grant), 32'h2);
    chk("t4_s_addr", bus.s_addr, 32'h2000_0004);
    chk("t4_s_wdata", bus.s_wdata, 32'h1234_5678);
    chk("t4_s_wstrb", 32'(bus.s_wstrb), 32'h6);
    cyc();
    smp();
    chk("t4_m0_waits", 32'(bus.m_ready), 32'h0);
    cyc();
    bus.s_ready = 1'b1;
    smp();
    chk("t4_m1_ready", 32'(bus.m_ready), 32'h2);
    cyc();
    bus.s_ready = 1'b0;
    bus.m_valid[1] = 1'b0;
    smp();
    chk("t4_bubble", 32'(bus.grant), 32'h0);
    cyc();
    smp();
    chk("t4_m0_grant", 32'(bus.grant), 32'h1);
    chk("t4_m0_addr", bus.s_addr, 32'h1000_0080);

    // reset while BUSY with slave stalled
    cyc();
    reset = 1'b1;
    smp();
    chk("t5_s_valid", 32'(bus.s_valid), 32'h0);
    chk("t5_grant", 32'(bus.grant), 32'h0);
    chk("t5_m_ready", 32'(bus.m_ready), 32'h0);

    // all four requesting, slave always ready
    cyc();
    reset = 1'b0;
    for (int i = 0; i < N; i++)
      set_m(i, 1'b1, 32'h3000_0000 + 32'(i * 16), 32'(i), 4'h0);
    bus.s_ready = 1'b1;
    exp_g = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0,
              4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    for (int i = 0; i < N; i++) mrc[i] = 0;
    for (int k = 0; k < 10; k++) begin
      smp();
      chk($sformatf("t2_grant_%0d", k), 32'(bus.grant), 32'(exp_g[k]));
      if (k < 8)
        for (int i = 0; i < N; i++) mrc[i] += int'(bus.m_ready[i]);
      cyc();
    end
    for (int i = 0; i < N; i++)
      chk($sformatf("t2_ready_cnt_%0d", i), 32'(mrc[i]), 32'h1);

    // after master 2 completes, 1 and 3 together -> 3 first
    bus.m_valid = 4'b0100;
    smp();
    cyc();
    smp();
    chk("t3_m2_ready", 32'(bus.m_ready), 32'h4);
    cyc();
    bus.m_valid = 4'b1010;
    smp();
    cyc();
    smp();
    chk("t3_grant3", 32'(bus.grant), 32'h8);
    cyc();
    bus.m_valid = '0;
    bus.s_ready = 1'b0;

`ifdef VIGNA_ARB_TIMEOUT_EN
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    set_m(0, 1'b1, 32'h4000_0000, 32'h0, 4'h0);
    sv_at = -1;
    rd_at = -1;
    rdat  = '0;
    svl   = 1'b1;
    for (int n = 0; n < 20; n++) begin
      smp();
      if (bus.s_valid && sv_at < 0) sv_at = n;
      if (bus.m_ready[0] && rd_at < 0) begin
        rd_at = n;
        rdat  = bus.m_rdata;
        svl   = bus.s_valid;
      end
      cyc();
      if (n == rd_at) bus.m_valid[0] = 1'b0;
    end
    chk("tmo_seen", 32'(rd_at >= 0), 32'h1);
    chk("tmo_delay", 32'(rd_at - sv_at), 32'd8);
    chk("tmo_rdata", rdat, 32'hDEAD_BEEF);
    chk("tmo_s_valid", 32'(svl), 32'h0);
    smp();
    chk("tmo_err", 32'(bus.timeout_err), 32'h1);
    repeat (3) cyc();
    smp();
    chk("tmo_err_sticky", 32'(bus.timeout_err), 32'h1);
`endif

    // randomized traffic, protocol-following masters
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      fin[i]   = 1'b0;
      waits[i] = 0;
    end
    bus.m_valid = '0;
    for (int c = 0; c < 600; c++) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        if (fin[i]) begin
          bus.m_valid[i] = 1'b0;
          pend[i] = 1'b0;
          fin[i]  = 1'b0;
        end else if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i]  = 1'b1;
          waits[i] = 0;
          set_m(i, 1'b1, $urandom, $urandom, 4'($urandom));
        end
      end
      bus.s_ready = ($urandom_range(2) != 0);
      bus.s_rdata = $urandom;
      smp();
      mr = bus.m_ready;
      for (int i = 0; i < N; i++) begin
        if (pend[i] && !fin[i]) begin
          if (mr[i]) begin
            fin[i] = 1'b1;
            chk($sformatf("fair_wait_m%0d", i),
                32'(waits[i] <= N - 1), 32'h1);
          end else if (mr != '0) begin
            waits[i]++;
          end
        end
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
